// File: rtl/reset_gen_pkg.sv
// Shared definitions for the reset sequencer: FSM states, reset-cause codes, default cycle
// constants for the board clock and a counter-width helper.
package reset_gen_pkg;

  typedef enum logic [1:0] {
    StPor     = 2'd0,
    StRun     = 2'd1,
    StBtn     = 2'd2,
    StStretch = 2'd3
  } rst_state_e;

  localparam logic [1:0] RST_CAUSE_POR = 2'd0;
  localparam logic [1:0] RST_CAUSE_BTN = 2'd1;
  localparam logic [1:0] RST_CAUSE_WDT = 2'd2;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefDebounceCyc = 20000;
  localparam int unsigned DefPorCyc      = 1024;
  localparam int unsigned DefStretchCyc  = 256;
  localparam int unsigned DefWdtCyc      = 16777216;

  // Bits needed for a counter that runs 0 .. n-1 (never less than one).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_gen_btn_debounce.sv
// Button conditioner: synchronises an asynchronous active-low pin, debounces it and emits a
// one-cycle pulse on each debounced press.
module reset_gen_btn_debounce
  import reset_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   pressed;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_n};
    pressed = ~sync_q[SYNC_STAGES-1];
    level_d = level_q;
    cnt_d   = '0;
    if (pressed != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  // Synchroniser resets to all ones so a released button reads as released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/reset_gen.sv
// Core reset sequencer: power-on hold, debounced button reset with stretch, reset counting and
// cause reporting. Optional watchdog built when RSTGEN_WDT_EN is defined.
module reset_gen
  import reset_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
  parameter int unsigned POR_CYC      = DefPorCyc,
  parameter int unsigned STRETCH_CYC  = DefStretchCyc,
  parameter int unsigned WDT_CYC      = DefWdtCyc
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       wdt_kick,
  output logic       rst_out,
  output logic       btn_level,
  output logic       btn_press,
  output logic [7:0] rst_count,
  output logic [1:0] rst_cause
);

  localparam int unsigned CntW = cnt_width(POR_CYC > STRETCH_CYC ? POR_CYC : STRETCH_CYC);

  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      count_q, count_d;
  logic [1:0]      cause_q, cause_d;
  logic            rst_out_q, rst_out_d;
  logic            wdt_trip;

  reset_gen_btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

`ifdef RSTGEN_WDT_EN
  localparam int unsigned WdtW = cnt_width(WDT_CYC);

  logic [WdtW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d    = '0;
    wdt_trip = 1'b0;
    if (state_q == StRun && !wdt_kick) begin
      if (wdt_q == WdtW'(WDT_CYC - 1)) begin
        wdt_trip = 1'b1;
      end else begin
        wdt_d = wdt_q + WdtW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_trip        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    cause_d = cause_q;
    case (state_q)
      StPor: begin
        if (cnt_q == CntW'(POR_CYC - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        cnt_d = '0;
        // Button has priority over a simultaneous watchdog trip.
        if (btn_press) begin
          state_d = StBtn;
          cause_d = RST_CAUSE_BTN;
        end else if (wdt_trip) begin
          state_d = StStretch;
          cause_d = RST_CAUSE_WDT;
        end
        if ((btn_press || wdt_trip) && count_q != 8'hff) begin
          count_d = count_q + 8'd1;
        end
      end
      StBtn: begin
        if (!btn_level) begin
          state_d = StStretch;
          cnt_d   = '0;
        end
      end
      StStretch: begin
        if (btn_press) begin
          state_d = StBtn;
        end else if (cnt_q == CntW'(STRETCH_CYC - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StPor;
    endcase
    rst_out_d = (state_d != StRun);
  end

  // rst_out asserts asynchronously with reset and only ever releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StPor;
      cnt_q     <= '0;
      count_q   <= '0;
      cause_q   <= RST_CAUSE_POR;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      cause_q   <= cause_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_count = count_q;
  assign rst_cause = cause_q;

endmodule
